// File: rtl/and_lane_pipe_if.sv
// Bundle of the and_lane_pipe data/handshake signals.
// The master side drives operands and the downstream ready.
// The slave side (the pipe itself) drives results and the upstream ready.
//
// Handshake rules, identical on both ends of the pipe:
//   A beat moves across a boundary on a rising edge where valid and ready are both 1.
//   A producer holds valid and its payload steady until the beat moves.
//   in_ready never depends on in_valid.
//   out_valid, y, y_red and busy come straight from registers.
interface and_lane_pipe_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [1:0]             mode;
    logic [LANES*WIDTH-1:0] a;
    logic [LANES*WIDTH-1:0] b;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] y;
    logic [LANES-1:0]       y_red;
    logic                   busy;

    modport master (
        output in_valid,
        output mode,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  y,
        input  y_red,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  mode,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output y,
        output y_red,
        output busy
    );
endinterface

// File: rtl/and_lane_pipe.sv
// Multi-lane AND-family gate array with an elastic valid/ready pipeline.
//
// The op result and its per-lane AND-reduce are computed combinationally from
// a/b/mode. Both are captured together into stage 0. Later stages only move data.
//
// Each stage loads when it is empty or when the stage behind it drains on the
// same edge. Empty stages therefore fill even while the output is stalled.
module and_lane_pipe #(
    parameter int WIDTH       = 8,
    parameter int LANES       = 16,
    parameter int PIPE_STAGES = 2
) (
    input logic          clk,
    input logic          rst,
    and_lane_pipe_if.slave bus
);
    localparam int DW   = LANES * WIDTH;
    localparam int LAST = PIPE_STAGES - 1;

    localparam logic [1:0] MODE_AND    = 2'd0;
    localparam logic [1:0] MODE_ANDN   = 2'd1;
    localparam logic [1:0] MODE_NAND   = 2'd2;
    localparam logic [1:0] MODE_LANEEN = 2'd3;

    // Combinational op result for the beat being presented.
    logic [DW-1:0]    op_y;
    logic [LANES-1:0] op_red;
    logic [WIDTH-1:0] lane_a;
    logic [WIDTH-1:0] lane_b;
    logic [WIDTH-1:0] lane_r;

    // Pipeline registers, index 0 is nearest the input.
    logic [PIPE_STAGES-1:0] stg_vld;
    logic [DW-1:0]          stg_data [PIPE_STAGES];
    logic [LANES-1:0]       stg_red  [PIPE_STAGES];

    // Load enables and the source each stage would load from.
    logic [PIPE_STAGES-1:0] stg_load;
    logic [PIPE_STAGES-1:0] src_vld;
    logic [DW-1:0]          src_data [PIPE_STAGES];
    logic [LANES-1:0]       src_red  [PIPE_STAGES];
    logic                   tail_full;

    // Per-lane bitwise op. No lane reads bits from any other lane.
    always_comb begin
        op_y   = '0;
        op_red = '0;
        lane_a = '0;
        lane_b = '0;
        lane_r = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_a = bus.a[l*WIDTH +: WIDTH];
            lane_b = bus.b[l*WIDTH +: WIDTH];
            case (bus.mode)
                MODE_AND:    lane_r = lane_a & lane_b;
                MODE_ANDN:   lane_r = lane_a & ~lane_b;
                MODE_NAND:   lane_r = ~(lane_a & lane_b);
                MODE_LANEEN: lane_r = (&lane_b) ? lane_a : '0;
                default:     lane_r = '0;
            endcase
            op_y[l*WIDTH +: WIDTH] = lane_r;
            op_red[l]              = &lane_r;
        end
    end

    // Stall chain: stage k may load unless it and every stage after it are
    // full while the output is blocked.
    always_comb begin
        stg_load  = '0;
        tail_full = 1'b1;
        for (int k = LAST; k >= 0; k--) begin
            tail_full   = tail_full & stg_vld[k];
            stg_load[k] = bus.out_ready | ~tail_full;
        end
    end

    // Stage 0 takes the new beat and later stages take their predecessor.
    always_comb begin
        src_vld = '0;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            if (k == 0) begin
                src_vld[k]  = bus.in_valid;
                src_data[k] = op_y;
                src_red[k]  = op_red;
            end else begin
                src_vld[k]  = stg_vld[k-1];
                src_data[k] = stg_data[k-1];
                src_red[k]  = stg_red[k-1];
            end
        end
    end

    // Pipeline registers. Data changes only when a valid beat is loaded,
    // so a drained stage keeps its last payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                stg_vld[k]  <= 1'b0;
                stg_data[k] <= '0;
                stg_red[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                if (stg_load[k]) begin
                    stg_vld[k] <= src_vld[k];
                    if (src_vld[k]) begin
                        stg_data[k] <= src_data[k];
                        stg_red[k]  <= src_red[k];
                    end
                end
            end
        end
    end

    // in_ready is the stage-0 load condition. It depends on out_ready and on
    // stage state, and never on in_valid.
    always_comb begin
        bus.in_ready  = stg_load[0];
        bus.out_valid = stg_vld[LAST];
        bus.y         = stg_data[LAST];
        bus.y_red     = stg_red[LAST];
        bus.busy      = |stg_vld;
    end
endmodule

// File: tb/tb_and_lane_pipe.sv
// Directed and randomised bench for and_lane_pipe using the default parameters.
module tb_and_lane_pipe;
    localparam int WIDTH = 8;
    localparam int LANES = 16;
    localparam int PS    = 2;
    localparam int DW    = LANES * WIDTH;
    localparam int CW    = DW + LANES;

    logic clk;
    logic rst;
    logic mon_en;

    and_lane_pipe_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

    and_lane_pipe #(.WIDTH(WIDTH), .LANES(LANES), .PIPE_STAGES(PS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and reset signal setup.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vec_cnt = 0;
    int err_cnt = 0;
    int occ     = 0;
    logic [CW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model, evaluated bit by bit. Returns {y_red, y}.
    function automatic logic [CW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [1:0] m);
        logic [DW-1:0]    y;
        logic [LANES-1:0] red;
        logic             en;
        logic             r;
        y   = '0;
        red = '0;
        for (int l = 0; l < LANES; l++) begin
            en = 1'b1;
            for (int i = 0; i < WIDTH; i++) en = en & b[l*WIDTH+i];
            red[l] = 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
                case (m)
                    2'd0:    r = a[l*WIDTH+i] & b[l*WIDTH+i];
                    2'd1:    r = a[l*WIDTH+i] & ~b[l*WIDTH+i];
                    2'd2:    r = ~(a[l*WIDTH+i] & b[l*WIDTH+i]);
                    default: r = a[l*WIDTH+i] & en;
                endcase
                y[l*WIDTH+i] = r;
                red[l]       = red[l] & r;
            end
        end
        return {red, y};
    endfunction

    // Scoreboard. Every cycle it checks busy against the model occupancy,
    // pops an expected value on each output transfer and pushes one on each acceptance.
    always @(negedge clk) begin
        logic [CW-1:0] e;
        logic          push;
        logic          pop;
        if (mon_en) begin
            check("busy", CW'(bus.busy), CW'(occ > 0));
            check("occ_max", CW'(occ <= PS), CW'(1));
            if (rst) begin
                exp_q.delete();
                occ = 0;
            end else begin
                push = bus.in_valid & bus.in_ready;
                pop  = bus.out_valid & bus.out_ready;
                if (pop) begin
                    if (exp_q.size() == 0) begin
                        check("sb_extra", CW'(1), CW'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_data", {bus.y_red, bus.y}, e);
                    end
                end
                if (push) exp_q.push_back(model(bus.a, bus.b, bus.mode));
                occ = occ + int'(push) - int'(pop);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic ordy);
        bus.in_valid  = v;
        bus.mode      = m;
        bus.a         = a;
        bus.b         = b;
        bus.out_ready = ordy;
    endtask

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] v;
        for (int w = 0; w < DW / 32; w++) v[w*32 +: 32] = $urandom();
        for (int l = 0; l < LANES; l++)
            if ($urandom_range(0, 3) == 0) v[l*WIDTH +: WIDTH] = '1;
        return v;
    endfunction

    logic [DW-1:0] ones;
    logic [DW-1:0] va;
    logic [DW-1:0] vb;
    logic [DW-1:0] yexp;
    logic [7:0]    l0_exp [4];
    logic [7:0]    got_l0 [8];
    int            idx;
    int            got_n;

    initial begin
        ones   = '1;
        mon_en = 1'b0;
        rst    = 1'b1;
        drive(1'b1, 2'd0, ones, ones, 1'b1);
        tick();
        mon_en = 1'b1;

        // Reset held with a valid beat presented: nothing may enter.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_idle", {bus.out_valid, bus.busy, bus.y_red, bus.y}, '0);
            tick();
        end
        rst = 1'b0;
        drive(1'b0, 2'd0, '0, '0, 1'b1);
        @(negedge clk);
        check("rst_inrdy", CW'(bus.in_ready), CW'(1));
        tick();

        // Basic ops on lane 0 (a=F0, b=3C), one beat per mode, back to back.
        l0_exp = '{8'h30, 8'hC0, 8'hCF, 8'h00};
        va = '0;
        vb = '0;
        va[7:0] = 8'hF0;
        vb[7:0] = 8'h3C;
        for (int c = 0; c < 6; c++) begin
            drive(c < 4, 2'(c), va, vb, 1'b1);
            @(negedge clk);
            if (c < PS) begin
                check("ops_lat", CW'(bus.out_valid), CW'(0));
            end else begin
                check("ops_y", {bus.out_valid, bus.y_red[0], bus.y[7:0]}, {1'b1, 1'b0, l0_exp[c-PS]});
            end
            tick();
        end

        // Reduce flag and lane isolation, mode 0 then mode 3.
        for (int m = 0; m < 2; m++) begin
            vb = ones;
            vb[5*WIDTH +: WIDTH] = 8'hFE;
            yexp = ones;
            yexp[5*WIDTH +: WIDTH] = (m == 0) ? 8'hFE : 8'h00;
            for (int c = 0; c <= PS; c++) begin
                drive(c == 0, (m == 0) ? 2'd0 : 2'd3, ones, vb, 1'b1);
                @(negedge clk);
                if (c == PS) begin
                    check("red_y", {bus.out_valid, bus.y}, {1'b1, yexp});
                    check("red_flags", CW'(bus.y_red), CW'(16'hFFDF));
                end
                tick();
            end
        end

        // Backpressure: six beats while out_ready is held low for five cycles.
        idx   = 0;
        got_n = 0;
        for (int c = 0; c < 40 && got_n < 6; c++) begin
            va = '0;
            va[7:0] = 8'(idx + 1);
            drive(idx < 6, 2'd0, va, ones, c >= 5);
            @(negedge clk);
            if (c >= 2 && c < 5) begin
                check("bp_inrdy", CW'(bus.in_ready), CW'(0));
                check("bp_hold", {bus.out_valid, bus.y[7:0]}, {1'b1, 8'h01});
                check("bp_accepted", CW'(idx), CW'(2));
            end
            if (bus.out_valid && bus.out_ready && got_n < 8) begin
                got_l0[got_n] = bus.y[7:0];
                got_n++;
            end
            if (bus.in_valid && bus.in_ready) idx++;
            tick();
        end
        check("bp_count", CW'(got_n), CW'(6));
        for (int i = 0; i < 6; i++) check("bp_order", CW'(got_l0[i]), CW'(i + 1));

        // Reset while two beats are in flight: neither may come out.
        drive(1'b1, 2'd0, ones, ones, 1'b0);
        tick();
        drive(1'b1, 2'd2, ones, '0, 1'b0);
        tick();
        rst = 1'b1;
        drive(1'b1, 2'd0, ones, ones, 1'b0);
        tick();
        rst = 1'b0;
        va = {LANES{8'hA5}};
        vb = {LANES{8'h0F}};
        for (int c = 0; c <= PS; c++) begin
            drive(c == 0, 2'd1, va, vb, 1'b1);
            @(negedge clk);
            if (c < PS) begin
                check("mid_rst_empty", CW'({bus.out_valid, bus.busy}), CW'({1'b0, c != 0}));
            end else begin
                check("mid_rst_y", {bus.out_valid, bus.y_red, bus.y}, {1'b1, 16'h0000, {LANES{8'hA0}}});
            end
            tick();
        end
        drive(1'b0, 2'd0, '0, '0, 1'b1);
        for (int c = 0; c < 3; c++) tick();

        // Random valid/ready bubbles with random operands and modes.
        for (int c = 0; c < 1000; c++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand_vec(), rand_vec(),
                  $urandom_range(0, 3) != 0);
            tick();
        end
        drive(1'b0, 2'd0, '0, '0, 1'b1);
        for (int c = 0; c < 10; c++) tick();
        check("sb_drain", CW'(exp_q.size()), CW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/and_lane_pipe.md
Name: and_lane_pipe

Overview:
- Parametrised, pipelined multi-lane AND-family gate array. Successor to the single-bit two-input AND cell used in the AES datapath.
- Operates on LANES independent WIDTH-bit channels. The default is 16 x 8 = the 128-bit AES state.
- Selectable op mode, per-lane AND-reduce flag, valid/ready elastic pipeline of PIPE_STAGES registers.
- Sits between the round-key/state registers and downstream masking/compare logic in aes_core.

Parameters:
- WIDTH, 8: bits per lane, >=1.
- LANES, 16: number of independent lanes, >=1.
- PIPE_STAGES, 2: register stages input-to-output, >=1. This is the unstalled latency in cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- mode  input  2  op select, sampled with the beat: 0 = A&B, 1 = A&~B, 2 = ~(A&B), 3 = A-pass-with-lane-enable (lane l = A_l when B_l is all-ones, else 0).
- a  input  LANES*WIDTH  operand A; lane l = a[l*WIDTH +: WIDTH].
- b  input  LANES*WIDTH  operand B, same packing.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- y  output  LANES*WIDTH  per-lane bitwise result.
- y_red  output  LANES  y_red[l] = AND-reduce of result lane l.
- busy  output  1  any stage holds a valid beat.

Behaviour:
- Reset (rst=1 at a clk edge): all stage valid flags clear and all stage data registers clear to 0.
  - Outputs after reset: out_valid=0, y=0, y_red=0, busy=0, in_ready=1.
  - In-flight beats are discarded and never emitted.
  - in_valid asserted during reset is ignored.
- Compute:
  - The op is evaluated combinationally on a/b/mode and captured into stage 1 on acceptance.
  - y_red is computed from the op result and captured with it in the same stage. It is not recomputed at the output.
  - Stages 2..PIPE_STAGES only shift data; no arithmetic.
- Handshake:
  - Input acceptance = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Stage k loads when it is empty or stage k+1 (or the output, for the last stage) is consuming this cycle.
  - in_ready = stage-1 load condition. It depends combinationally on out_ready only through the stall chain; no path from in_valid to in_ready.
- Latency and throughput:
  - Beat accepted at edge N appears with out_valid=1 after edge N+PIPE_STAGES-1 when there is no stall. Observable in the cycle following edge N+PIPE_STAGES-1, i.e. PIPE_STAGES cycles after the input was presented.
  - Sustained throughput is 1 beat/cycle with out_ready held high.
  - Beats leave in acceptance order; no reordering, duplication or loss.
- Stall:
  - While out_valid=1 and out_ready=0, y and y_red hold stable.
  - Bubbles collapse: an empty stage loads even when downstream is stalled.
  - Maximum occupancy is PIPE_STAGES beats. When all stages are valid and out_ready=0, in_ready=0.
- Simultaneous events:
  - Full pipeline with out_ready=1 and in_valid=1: accept and emit in the same cycle, occupancy unchanged.
  - Empty pipeline: in_ready=1 regardless of out_ready.
- busy = OR of stage valid flags, registered-state-derived (no combinational input path).
- Mode is per-beat: beats with different modes may be back-to-back; each result uses its own captured mode.
- Width rules: purely bitwise, no carries. Lanes are fully independent; no bit of lane l affects lane m≠l.

Test Plan:
- Reset/idle:
  - Stimulus: assert rst for 2 cycles with in_valid=1, a=b=all-ones.
  - Required: out_valid=0, y=0, y_red=0, busy=0 throughout. in_ready=1 on the first cycle after rst drops.
- Basic ops and latency (defaults, PIPE_STAGES=2):
  - Stimulus: lane0 a=0xF0, b=0x3C, one beat per mode 0..3 back-to-back, out_ready=1.
  - Required, consecutive cycles starting 2 cycles after first input:
    - mode0: y lane0=0x30, y_red[0]=0.
    - mode1: lane0=0xC0.
    - mode2: lane0=0xCF.
    - mode3: lane0=0x00.
- Reduce and lane isolation:
  - Stimulus: mode 0, a=all-ones, b=all-ones except lane 5 b=0xFE.
  - Required: y_red=16'hFFDF, lane5 y=0xFE, all other lanes 0xFF. Repeat with mode 3: lane5 y=0x00, others 0xFF.
- Backpressure:
  - Stimulus: stream 6 beats with a lane0 = 1..6, mode 0, b=all-ones, hold out_ready=0 for 5 cycles then 1.
  - Required: in_ready falls after 2 accepted beats. y holds lane0=0x01 during the stall. Outputs appear in order 1..6, none lost or duplicated.
- Random bubbles:
  - Stimulus: random in_valid/out_ready over 1000 cycles with random a/b/mode.
  - Required: scoreboard match on every transfer. busy matches the model's occupancy>0. Occupancy never exceeds 2.
- Reset mid-operation:
  - Stimulus: 2 beats in flight, assert rst for 1 cycle.
  - Required: neither beat is emitted. A new beat after reset emerges with exactly PIPE_STAGES latency and the correct value.
